// File: rtl/operand_forward_unit.sv
// ID-stage operand resolver and ID/EX operand register.
// Each source operand comes from the EX, MEM or WB forward paths or from the register file.
// A load in EX feeding the instruction in ID stalls IF/ID for one cycle and sends a bubble
// into EX. A saturating counter records the load-use stall cycles.
module operand_forward_unit #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,

  // Instruction in ID
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [31:0]            rf_rs1_data,
  input  logic [31:0]            rf_rs2_data,

  // EX stage producer
  input  logic [4:0]             ex_rd,
  input  logic                   ex_wen,
  input  logic                   ex_is_load,
  input  logic [31:0]            ex_fwd_data,

  // MEM stage producer
  input  logic [4:0]             mem_rd,
  input  logic                   mem_wen,
  input  logic [31:0]            mem_fwd_data,

  // WB stage producer
  input  logic [4:0]             wb_rd,
  input  logic                   wb_wen,
  input  logic [31:0]            wb_data,

  // Redirect
  input  logic                   flush,

  output logic                   stall,
  output logic [31:0]            ex_op1_q,
  output logic [31:0]            ex_op2_q,
  output logic                   ex_valid_q,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {
    StRun,
    StLoadStall
  } state_e;

  state_e state_q, state_d;

  logic                   rs1_ex_hit, rs1_mem_hit, rs1_wb_hit;
  logic                   rs2_ex_hit, rs2_mem_hit, rs2_wb_hit;
  logic                   hazard;
  logic [31:0]            op1_d, op2_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // A source matches a stage only when it is really read, is not x0 and the stage writes it.
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd,
                                     input logic       wen);
    return use_src && (rs != 5'd0) && (rd == rs) && wen;
  endfunction

  // Youngest producer wins; an EX load has no data yet and is never forwarded from EX.
  function automatic logic [31:0] resolve(input logic [4:0]  rs,
                                          input logic        ex_hit,
                                          input logic        ex_load,
                                          input logic        mem_hit,
                                          input logic        wb_hit,
                                          input logic [31:0] ex_val,
                                          input logic [31:0] mem_val,
                                          input logic [31:0] wb_val,
                                          input logic [31:0] rf_val);
    logic [31:0] val;
    if (rs == 5'd0) begin
      val = 32'd0;
    end else if (ex_hit && !ex_load) begin
      val = ex_val;
    end else if (mem_hit) begin
      val = mem_val;
    end else if (wb_hit) begin
      val = wb_val;
    end else begin
      // WB is forwarded above, so no register-file write-through is assumed here.
      val = rf_val;
    end
    return val;
  endfunction

  // Per-source, per-stage match detection.
  always_comb begin
    rs1_ex_hit  = src_match(id_use_rs1, id_rs1, ex_rd, ex_wen);
    rs1_mem_hit = src_match(id_use_rs1, id_rs1, mem_rd, mem_wen);
    rs1_wb_hit  = src_match(id_use_rs1, id_rs1, wb_rd, wb_wen);
    rs2_ex_hit  = src_match(id_use_rs2, id_rs2, ex_rd, ex_wen);
    rs2_mem_hit = src_match(id_use_rs2, id_rs2, mem_rd, mem_wen);
    rs2_wb_hit  = src_match(id_use_rs2, id_rs2, wb_rd, wb_wen);
  end

  // Operand selection for both sources.
  always_comb begin
    op1_d = resolve(id_rs1, rs1_ex_hit, ex_is_load, rs1_mem_hit, rs1_wb_hit,
                    ex_fwd_data, mem_fwd_data, wb_data, rf_rs1_data);
    op2_d = resolve(id_rs2, rs2_ex_hit, ex_is_load, rs2_mem_hit, rs2_wb_hit,
                    ex_fwd_data, mem_fwd_data, wb_data, rf_rs2_data);
  end

  // Load-use detection, stall generation and next-state selection.
  always_comb begin
    hazard  = id_valid && ex_is_load && (rs1_ex_hit || rs2_ex_hit);
    stall   = 1'b0;
    state_d = StRun;
    unique case (state_q)
      StRun: begin
        // rst_n gating keeps stall low while reset is held, whatever the inputs are.
        stall   = rst_n && hazard && !flush;
        state_d = stall ? StLoadStall : StRun;
      end
      StLoadStall: begin
        // The load now sits in MEM and is forwarded from there, so no second stall.
        stall   = 1'b0;
        state_d = StRun;
      end
      default: begin
        stall   = 1'b0;
        state_d = StRun;
      end
    endcase
    if (flush) begin
      state_d = StRun;
    end
  end

  // Hazard FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // ID/EX operand register; flush or stall inserts a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op1_q   <= 32'd0;
      ex_op2_q   <= 32'd0;
    end else if (flush || stall) begin
      ex_valid_q <= 1'b0;
      ex_op1_q   <= 32'd0;
      ex_op2_q   <= 32'd0;
    end else begin
      ex_valid_q <= id_valid;
      ex_op1_q   <= op1_d;
      ex_op2_q   <= op2_d;
    end
  end

  // Saturating load-use stall counter; flush already suppresses stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
